// File: rtl/reaction_timer_fsm.sv
// Reaction-time game controller: arms on a button press, waits a pseudo-random
// delay, lights GO, then counts ms ticks until the next press freezes the result.
module reaction_timer_fsm #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 11,
  parameter int unsigned LOCKOUT_MS   = 20,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        b,
  output logic [23:0] timecount,
  output logic        led,
  output logic        done,
  output logic        false_start,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_GO    = 3'd2,
    S_DONE  = 3'd3,
    S_FALSE = 3'd4
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
  localparam int LW = (LOCKOUT_MS > 0) ? $clog2(LOCKOUT_MS + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DELAY_MIN = DW'(MIN_DELAY_MS);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_MS);

  state_t        state_q, state_d;
  logic [23:0]   tc_q, tc_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [PW-1:0] presc;
  logic [LW-1:0] lockout;
  logic [15:0]   lfsr;
  logic          s1, s2, s3;
  logic [1:0]    warm;
  logic          tick, press, moving;

  // warm gates the first cycles after reset so a button already held low
  // (synchronizer preset to 1) is not mistaken for a fresh press.
  assign tick   = (presc == PRE_LAST);
  assign press  = s3 & ~s2 & (lockout == '0) & (warm == 2'd3);
  assign moving = (state_d != state_q);

  // NOTE: every flop uses <= so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s3   <= 1'b1;
      warm <= '0;
      lfsr <= LFSR_SEED;
    end else begin
      s1 <= b;
      s2 <= s1;
      s3 <= s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc   <= '0;
      lockout <= '0;
    end else begin
      if (moving || tick) presc <= '0;
      else                presc <= presc + PW'(1);
      if (press)                        lockout <= LOCK_LOAD;
      else if (tick && lockout != '0)   lockout <= lockout - LW'(1);
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    delay_d = delay_q;
    case (state_q)
      S_IDLE, S_DONE, S_FALSE: begin
        if (press) begin
          state_d = S_WAIT;
          tc_d    = '0;
          delay_d = DELAY_MIN + DW'(lfsr[RAND_BITS-1:0]);
        end
      end
      S_WAIT: begin
        if (press) begin
          state_d = S_FALSE;
        end else if (tick) begin
          if (delay_q == '0) state_d = S_GO;
          else               delay_d = delay_q - DW'(1);
        end
      end
      S_GO: begin
        // A press on a tick cycle wins, freezing the pre-increment count.
        if (press)                        state_d = S_DONE;
        else if (tick && tc_q != '1)      tc_d    = tc_q + 24'd1;
      end
      default: begin
        state_d = S_IDLE;
        tc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      tc_q        <= '0;
      delay_q     <= '0;
      led         <= 1'b0;
      done        <= 1'b0;
      false_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      tc_q        <= tc_d;
      delay_q     <= delay_d;
      led         <= (state_d == S_GO);
      done        <= (state_d == S_DONE);
      false_start <= (state_d == S_FALSE);
    end
  end

  assign state     = state_q;
  assign timecount = tc_q;

endmodule
